sha512_msg_ctrl: RTL
====================

# sha512_msg_ctrl

Multi-block message sequencer in front of a single `sha512_block` compression core. It accepts a stream of pre-padded 1024-bit message blocks over a valid/ready handshake and selects the initial hash value or the chained intermediate hash per block. It issues one-cycle start pulses to the core and returns the final 512-bit digest over a second valid/ready handshake. It also recovers from aborts and from a hung core.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 127 — maximum cycles to wait for `core_output_valid` after a start pulse before flagging an error.

Ports:
- `clk`  in  1  — single clock; all logic on rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `abort`  in  1  — synchronous message abort.
- `blk_valid`  in  1  — upstream block valid.
- `blk_ready`  out  1  — block accepted when `blk_valid && blk_ready`.
- `blk_data`  in  1024  — padded message block, word 0 in [1023:960].
- `blk_last`  in  1  — block is the final block of its message.
- `core_H_in`  out  512  — chaining value to core.
- `core_M_in`  out  1024  — message block to core.
- `core_input_valid`  out  1  — one-cycle start pulse to core.
- `core_H_out`  in  512  — core result.
- `core_output_valid`  in  1  — one-cycle core completion pulse.
- `digest`  out  512  — final hash.
- `digest_valid`  out  1  — digest available.
- `digest_ready`  in  1  — digest consumed when `digest_valid && digest_ready`.
- `busy`  out  1  — high in every state except IDLE.
- `error`  out  1  — sticky core-timeout flag.
- `blk_count`  out  16  — blocks completed in the current message; saturates at 16'hFFFF.

## Operation

- FSM states: IDLE, ISSUE, WAIT, DONE, DRAIN, ERR.
- `first` flag:
  - Set at reset, after digest handoff, after abort, and on entry to ERR.
  - Cleared when a block is accepted.
- IDLE:
  - `blk_ready`=1.
  - On accept:
    - Latch `blk_data` into `core_M_in` and `blk_last` into `last_r`.
    - `core_H_in` <= `first` ? SHA-512 IV : `chain_r`.
    - If `first`, clear `blk_count`.
    - Go to ISSUE.
- ISSUE:
  - `core_input_valid`=1 for exactly this cycle.
  - Clear the timer.
  - Go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - On `core_output_valid`:
    - `chain_r` <= `core_H_out`.
    - `blk_count` += 1, saturating.
    - If `last_r`: `digest` <= `core_H_out`, go to DONE.
    - Otherwise go to IDLE.
  - If the timer reaches `TIMEOUT_CYCLES` with no pulse, go to ERR.
- DONE:
  - `digest_valid`=1.
  - Hold `digest` stable until `digest_ready`, then go to IDLE.
- ERR:
  - `error`=1 and `blk_ready`=0 until `abort` or reset.
- `abort`:
  - From IDLE, DONE or ERR: go to IDLE, clear `error`, `digest_valid` and `blk_count`.
  - From ISSUE or WAIT: go to DRAIN.
- DRAIN:
  - `blk_ready`=0.
  - Wait for `core_output_valid` (result discarded) or timeout, then go to IDLE.
  - Never leave the core running with a new block pending.
- `core_output_valid` is ignored outside WAIT and DRAIN.
- `abort` takes priority over a simultaneous `core_output_valid`, block accept, or digest handoff.
- Timer width: $clog2(TIMEOUT_CYCLES+1); it does not wrap.

## Timing

- Reset values:
  - State IDLE, `first`=1.
  - `blk_ready`=1 (combinational from state; forced 0 while `rst` is low).
  - `core_input_valid`=0, `core_M_in`=0, `core_H_in`=IV.
  - `digest`=0, `digest_valid`=0.
  - `busy`=0, `error`=0, `blk_count`=0.
- Block accept at edge N: `core_input_valid` high during cycle N+1.
- `core_H_in` and `core_M_in` stay stable from ISSUE until the next accept.
- Core pulse at edge M (last block): `digest_valid` rises in cycle M+1.
- Per-block overhead beyond core latency: 2 cycles (accept + issue).
- `blk_ready` is a function of state only, with no combinational path from `blk_valid`.
- The core must present `core_output_valid` no earlier than 1 cycle after the start pulse.

## Structure

- Shared package `sha2_pkg` holds:
  - `SHA512_IV` (512-bit).
  - State enum `sha512_ctrl_state_t`.
  - Block and digest width constants.
- The IV source is the existing `sha512_H_0` instance or the package constant. There is no other sub-module.
- The core itself is instantiated by the parent, not inside this block.

## Test plan

- Single block "abc" (61626380…0018, `blk_last`=1):
  - `digest` = ddaf35a193617aba…2a9ac94fa54ca49f.
  - `blk_count`=1.
  - Exactly one `core_input_valid` pulse.
- Null message (8000…0000, `blk_last`=1):
  - `digest` = cf83e1357eefb8bd…f927da3e.
- Two-block 896-bit "abcdefghbcdefghi…nopqrstu":
  - First block uses IV; second block's `core_H_in` equals the first result.
  - `digest` = 8e959b75dae313da…874be909.
  - `blk_count`=2.
- Back-to-back messages with `digest_ready` held low 5 cycles:
  - `blk_ready`=0 and `digest` stable throughout.
  - The second message restarts from IV with `blk_count` cleared.
- Core model with no `core_output_valid`:
  - `error` rises exactly `TIMEOUT_CYCLES` cycles after WAIT entry.
  - `abort` clears it and returns `blk_ready`=1.
- `abort` in WAIT:
  - State goes to DRAIN with `blk_ready`=0.
  - The late `core_output_valid` is discarded (no `digest_valid`).
  - The next "abc" message yields the correct digest.
- Reset asserted mid-WAIT:
  - All outputs take reset values immediately, asynchronously.

Source files
------------

// File: rtl/sha2_pkg.sv
// sha2_pkg: shared SHA-2 constants and controller state encoding.
// Holds block/digest widths, the SHA-512 IV and the sequencer FSM enum.
package sha2_pkg;

  localparam int SHA512_BLK_W = 1024;
  localparam int SHA512_DIG_W = 512;

  localparam logic [SHA512_DIG_W-1:0] SHA512_IV = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
    64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
    64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4,
    S_ERR   = 3'd5
  } sha512_ctrl_state_t;

endpackage

// File: rtl/sha512_msg_ctrl.sv
// sha512_msg_ctrl: sequences padded 1024-bit blocks through one
// sha512_block core, chaining H; blk_* in, core_* to core, digest_* out.
import sha2_pkg::*;

module sha512_msg_ctrl #(
  parameter int TIMEOUT_CYCLES = 127
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    abort,
  input  logic                    blk_valid,
  output logic                    blk_ready,
  input  logic [SHA512_BLK_W-1:0] blk_data,
  input  logic                    blk_last,
  output logic [SHA512_DIG_W-1:0] core_H_in,
  output logic [SHA512_BLK_W-1:0] core_M_in,
  output logic                    core_input_valid,
  input  logic [SHA512_DIG_W-1:0] core_H_out,
  input  logic                    core_output_valid,
  output logic [SHA512_DIG_W-1:0] digest,
  output logic                    digest_valid,
  input  logic                    digest_ready,
  output logic                    busy,
  output logic                    error,
  output logic [15:0]             blk_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);

  sha512_ctrl_state_t state;

  logic                    first;
  logic                    last_r;
  logic [TW-1:0]           timer;
  logic [SHA512_DIG_W-1:0] chain_r;

  logic          tmr_hit;
  logic [TW-1:0] tmr_nx;
  logic [15:0]   cnt_nx;

  // tmr_hit marks the last cycle of the wait window
  assign tmr_hit = (timer == T_MAX);
  assign tmr_nx  = tmr_hit ? timer : timer + 1'b1;
  assign cnt_nx  = (&blk_count) ? blk_count : blk_count + 1'b1;

  // blk_ready depends on state only; held low while in reset
  assign blk_ready        = rst && (state == S_IDLE);
  assign core_input_valid = (state == S_ISSUE);
  assign digest_valid     = (state == S_DONE);
  assign error            = (state == S_ERR);
  assign busy             = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      first     <= 1'b1;
      last_r    <= 1'b0;
      timer     <= '0;
      core_M_in <= '0;
      core_H_in <= SHA512_IV;
      chain_r   <= SHA512_IV;
      digest    <= '0;
      blk_count <= '0;
    end else begin
      if (abort) first <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (abort) begin
            blk_count <= '0;
          end else if (blk_valid) begin
            core_M_in <= blk_data;
            last_r    <= blk_last;
            core_H_in <= first ? SHA512_IV : chain_r;
            if (first) blk_count <= '0;
            first     <= 1'b0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= '0;
          state <= abort ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          if (abort) begin
            // core is still running: let it finish before accepting
            timer <= tmr_nx;
            state <= S_DRAIN;
          end else if (core_output_valid) begin
            chain_r   <= core_H_out;
            blk_count <= cnt_nx;
            if (last_r) begin
              digest <= core_H_out;
              state  <= S_DONE;
            end else begin
              state <= S_IDLE;
            end
          end else if (tmr_hit) begin
            first <= 1'b1;
            state <= S_ERR;
          end else begin
            timer <= tmr_nx;
          end
        end
        S_DONE: begin
          if (abort) begin
            blk_count <= '0;
            state     <= S_IDLE;
          end else if (digest_ready) begin
            first <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (core_output_valid || tmr_hit) state <= S_IDLE;
          else timer <= tmr_nx;
        end
        S_ERR: begin
          if (abort) begin
            blk_count <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
